// File: rtl/busblaster_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | busblaster_pkg : shared state encoding and mode constants          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package busblaster_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam logic MODE_JTAG = 1'b0;
  localparam logic MODE_SWD  = 1'b1;

endpackage : busblaster_pkg
`default_nettype wire

// File: rtl/pulse_stretch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_stretch : load-on-pulse down-counter, active while non-zero  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pulse_stretch #(
  parameter int LEN = 1000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  output logic active_o
);

  localparam int CW = $clog2(LEN + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A load coincident with expiry simply reloads, so the output never gaps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(LEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_o = (cnt_q != '0);

endmodule : pulse_stretch
`default_nettype wire

// File: rtl/jtag_drive_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_drive_ctrl : JTAG/SWD buffer-enable sequencer with hi-Z       |
// | turnaround, nSRST pulse stretcher and activity LED. Rev 1.0        |
// +--------------------------------------------------------------------+
module jtag_drive_ctrl
  import busblaster_pkg::*;
#(
  parameter int TURN_CYCLES = 4,
  parameter int SRST_CYCLES = 1000,
  parameter int LED_CYCLES  = 2000000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic req_en,
  input  logic req_swd,
  input  logic swdio_dir,
  input  logic srst_req,
  input  logic activity,
  output logic swd_sel,
  output logic tck_oe_n,
  output logic tdi_oe_n,
  output logic tms_oe_n,
  output logic trst_oe_n,
  output logic srst_oe_n,
  output logic led_n,
  output logic busy
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tgt_q, tgt_d;
  logic          cur_q, cur_d;
  logic          sel_q, sel_d;
  logic          dir_q;
  logic          tck_oe_n_q, jtag_oe_n_q, swd_drv_q, busy_q;
  logic          win_start;
  logic          srst_act, led_act;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    cur_d     = cur_q;
    sel_d     = sel_q;
    win_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_en) begin
          state_d   = TURN;
          win_start = 1'b1;
        end
      end
      TURN: begin
        if (!req_en) begin
          state_d = IDLE;
        end else if (req_swd != tgt_q) begin
          win_start = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = DRIVE;
          cur_d   = tgt_q;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      DRIVE: begin
        if (!req_en) begin
          state_d = IDLE;
        end else if (req_swd != cur_q) begin
          state_d   = TURN;
          win_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Mux select only moves on a (re)started window, when every driver is going hi-Z.
    if (win_start) begin
      tgt_d = req_swd;
      sel_d = req_swd;
      cnt_d = TW'(TURN_CYCLES - 1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tgt_q       <= MODE_JTAG;
      cur_q       <= MODE_JTAG;
      sel_q       <= MODE_JTAG;
      dir_q       <= 1'b0;
      tck_oe_n_q  <= 1'b1;
      jtag_oe_n_q <= 1'b1;
      swd_drv_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      cur_q       <= cur_d;
      sel_q       <= sel_d;
      dir_q       <= swdio_dir;
      tck_oe_n_q  <= (state_d != DRIVE);
      jtag_oe_n_q <= !((state_d == DRIVE) && (cur_d == MODE_JTAG));
      swd_drv_q   <= (state_d == DRIVE) && (cur_d == MODE_SWD);
      busy_q      <= (state_d == TURN);
    end
  end

  pulse_stretch #(.LEN(SRST_CYCLES)) u_srst (
    .clk_i    (CLK),
    .rst_n_i  (nRST),
    .load_i   (srst_req),
    .active_o (srst_act)
  );

  pulse_stretch #(.LEN(LED_CYCLES)) u_led (
    .clk_i    (CLK),
    .rst_n_i  (nRST),
    .load_i   (activity),
    .active_o (led_act)
  );

  assign swd_sel   = sel_q;
  assign tck_oe_n  = tck_oe_n_q;
  assign tdi_oe_n  = jtag_oe_n_q;
  assign trst_oe_n = jtag_oe_n_q;
  // SWDIO direction follows the registered host request while SWD is driving.
  assign tms_oe_n  = swd_drv_q ? ~dir_q : jtag_oe_n_q;
  assign srst_oe_n = ~srst_act;
  assign led_n     = ~(led_act | srst_act);
  assign busy      = busy_q;

endmodule : jtag_drive_ctrl
`default_nettype wire

// File: tb/tb_jtag_drive_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jtag_drive_ctrl : directed + randomized bench with reference    |
// | model of the drive sequencer. Rev 1.0                              |
// +--------------------------------------------------------------------+
module tb_jtag_drive_ctrl;

  localparam int TURN = 4;
  localparam int SRST = 1000;
  localparam int LED  = 300;

  logic CLK = 1'b0;
  logic nRST, req_en, req_swd, swdio_dir, srst_req, activity;
  logic swd_sel, tck_oe_n, tdi_oe_n, tms_oe_n, trst_oe_n, srst_oe_n, led_n, busy;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  jtag_drive_ctrl #(.TURN_CYCLES(TURN), .SRST_CYCLES(SRST), .LED_CYCLES(LED)) dut (
    .CLK(CLK), .nRST(nRST), .req_en(req_en), .req_swd(req_swd),
    .swdio_dir(swdio_dir), .srst_req(srst_req), .activity(activity),
    .swd_sel(swd_sel), .tck_oe_n(tck_oe_n), .tdi_oe_n(tdi_oe_n),
    .tms_oe_n(tms_oe_n), .trst_oe_n(trst_oe_n), .srst_oe_n(srst_oe_n),
    .led_n(led_n), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Reference: phase 0 = nothing requested, 1 = counting a hi-Z window, 2 = driving.
  int m_phase = 0, m_left = 0, m_srst = 0, m_led = 0;
  bit m_tgt = 0, m_cur = 0, m_sel = 0, m_dir = 0;

  always @(posedge CLK) begin
    if (!nRST) begin
      m_phase = 0; m_left = 0; m_srst = 0; m_led = 0;
      m_tgt = 0; m_cur = 0; m_sel = 0; m_dir = 0;
    end else begin
      if (m_phase == 0) begin
        if (req_en) begin m_phase = 1; m_tgt = req_swd; m_sel = req_swd; m_left = TURN - 1; end
      end else if (m_phase == 1) begin
        if (!req_en) m_phase = 0;
        else if (req_swd != m_tgt) begin m_tgt = req_swd; m_sel = req_swd; m_left = TURN - 1; end
        else if (m_left == 0) begin m_phase = 2; m_cur = m_tgt; end
        else m_left = m_left - 1;
      end else begin
        if (!req_en) m_phase = 0;
        else if (req_swd != m_cur) begin
          m_phase = 1; m_tgt = req_swd; m_sel = req_swd; m_left = TURN - 1;
        end
      end
      m_dir  = swdio_dir;
      m_srst = srst_req ? SRST : (m_srst > 0 ? m_srst - 1 : 0);
      m_led  = activity ? LED : (m_led > 0 ? m_led - 1 : 0);
    end
  end

  task automatic cmp(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  logic p_tck = 1'b1, p_sel = 1'b0;

  always @(negedge CLK) begin
    if (chk_en) begin
      bit drv, jtag, swd;
      drv  = (m_phase == 2);
      jtag = drv && !m_cur;
      swd  = drv && m_cur;
      cmp("swd_sel",   swd_sel,   m_sel);
      cmp("tck_oe_n",  tck_oe_n,  !drv);
      cmp("tdi_oe_n",  tdi_oe_n,  !jtag);
      cmp("trst_oe_n", trst_oe_n, !jtag);
      cmp("tms_oe_n",  tms_oe_n,  swd ? !m_dir : !jtag);
      cmp("srst_oe_n", srst_oe_n, m_srst == 0);
      cmp("led_n",     led_n,     !(m_srst > 0 || m_led > 0));
      cmp("busy",      busy,      m_phase == 1);
      if (!p_tck && !tck_oe_n) cmp("sel_stable_in_drive", swd_sel, p_sel);
      p_tck = tck_oe_n;
      p_sel = swd_sel;
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    int n;
    nRST = 0; req_en = 0; req_swd = 0; swdio_dir = 0; srst_req = 0; activity = 0;
    repeat (3) step();
    chk_en = 1'b1;
    nRST = 1;
    step();
    lit("rst_tck", tck_oe_n, 1); lit("rst_sel", swd_sel, 0);
    lit("rst_led", led_n, 1);    lit("rst_busy", busy, 0);
    lit("rst_srst", srst_oe_n, 1);

    // Enable in JTAG: four hi-Z cycles, then all four drivers on.
    req_en = 1;
    for (int i = 0; i < TURN; i++) begin
      step();
      lit("jtag_win_tck", tck_oe_n, 1); lit("jtag_win_busy", busy, 1);
    end
    step();
    lit("jtag_tck", tck_oe_n, 0); lit("jtag_tdi", tdi_oe_n, 0);
    lit("jtag_tms", tms_oe_n, 0); lit("jtag_trst", trst_oe_n, 0);

    // Switch to SWD.
    req_swd = 1; swdio_dir = 1;
    step();
    lit("swd_win_tck", tck_oe_n, 1); lit("swd_win_sel", swd_sel, 1);
    repeat (TURN - 1) step();
    lit("swd_win_end", tck_oe_n, 1);
    step();
    lit("swd_tck", tck_oe_n, 0); lit("swd_tdi", tdi_oe_n, 1);
    lit("swd_trst", trst_oe_n, 1); lit("swd_tms_host", tms_oe_n, 0);
    swdio_dir = 0;
    step();
    lit("swd_tms_tgt", tms_oe_n, 1);

    // Mode toggles mid-window restart it.
    req_swd = 0; step(); step();
    req_swd = 1; step(); lit("restart1_sel", swd_sel, 1);
    step();
    req_swd = 0; step(); lit("restart2_sel", swd_sel, 0);
    for (int i = 0; i < TURN - 1; i++) begin
      step();
      lit("restart_busy", busy, 1);
    end
    step();
    lit("restart_tdi", tdi_oe_n, 0);

    // nSRST pulse length, then retrigger at 600.
    srst_req = 1; step(); srst_req = 0;
    n = 0;
    while (srst_oe_n == 1'b0 && n < 3000) begin n++; step(); end
    lit("srst_len", n, SRST);
    srst_req = 1; step();
    n = 0;
    while (srst_oe_n == 1'b0 && n < 5000) begin
      n++;
      srst_req = (n == 600);
      step();
    end
    srst_req = 0;
    lit("srst_retrig_len", n, SRST + 600);

    // Disable beats mode change; nSRST pulse keeps running.
    srst_req = 1; step(); srst_req = 0;
    req_en = 0; req_swd = 1; step();
    lit("dis_busy", busy, 0); lit("dis_tck", tck_oe_n, 1);
    lit("dis_sel", swd_sel, 0); lit("dis_srst", srst_oe_n, 0);
    req_swd = 0;

    // Reset mid-pulse and mid-LED while driving.
    req_en = 1;
    repeat (TURN + 1) step();
    lit("pre_rst_tck", tck_oe_n, 0);
    activity = 1; step(); activity = 0;
    lit("pre_rst_led", led_n, 0);
    nRST = 0; step(); nRST = 1;
    lit("mid_rst_srst", srst_oe_n, 1); lit("mid_rst_led", led_n, 1);
    lit("mid_rst_tck", tck_oe_n, 1);   lit("mid_rst_tms", tms_oe_n, 1);
    req_en = 0; step();

    // LED on-time after a single activity pulse.
    activity = 1; step(); activity = 0;
    n = 0;
    while (led_n == 1'b0 && n < 2000) begin n++; step(); end
    lit("led_len", n, LED);

    // Randomized traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      nRST      = ($urandom_range(999) != 0);
      req_en    = ($urandom_range(24) != 0) ? (req_en | ($urandom_range(3) == 0)) : 1'b0;
      if ($urandom_range(29) == 0) req_swd = ~req_swd;
      swdio_dir = 1'($urandom);
      srst_req  = ($urandom_range(1499) == 0);
      activity  = ($urandom_range(199) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_jtag_drive_ctrl
`default_nettype wire
